// File: rtl/neighbor_table.sv
// ============================================================================
// neighbor_table : register-based neighbour table with write/lookup/best-hop scan
// Rev 1.0
// ============================================================================
`default_nettype none

module neighbor_table #(
  parameter int MAX_NEIGHBORS = 16,
  parameter int WORD_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [WORD_WIDTH-1:0] nodeID,
  input  logic [WORD_WIDTH-1:0] nodeEnergy,
  input  logic [WORD_WIDTH-1:0] nodeHops,
  input  logic [WORD_WIDTH-1:0] nodeQValue,
  input  logic                  rd_req,
  input  logic [WORD_WIDTH-1:0] rd_id,
  input  logic                  scan_req,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic                  clr,
  output logic [WORD_WIDTH-1:0] mSourceID,
  output logic [WORD_WIDTH-1:0] mHopsFromCH,
  output logic [WORD_WIDTH-1:0] mQValue,
  output logic [WORD_WIDTH-1:0] mEnergyLeft,
  output logic                  rd_hit,
  output logic [WORD_WIDTH-1:0] bestID,
  output logic [WORD_WIDTH-1:0] bestQValue,
  output logic                  best_valid,
  output logic [WORD_WIDTH-1:0] neighborCount,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_drop
);

  localparam int AW = $clog2(MAX_NEIGHBORS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(MAX_NEIGHBORS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WSEARCH = 3'd1,
    S_WRITE   = 3'd2,
    S_RSEARCH = 3'd3,
    S_SCAN    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d, match_idx_q, match_idx_d;
  logic [WORD_WIDTH-1:0] op_id_q, op_id_d, op_energy_q, op_energy_d;
  logic [WORD_WIDTH-1:0] op_hops_q, op_hops_d, op_qv_q, op_qv_d, my_hops_q, my_hops_d;
  logic match_found_q, match_found_d, drop_q, drop_d;
  logic [WORD_WIDTH-1:0] m_src_q, m_src_d, m_hops_q, m_hops_d, m_qv_q, m_qv_d, m_energy_q, m_energy_d;
  logic rd_hit_q, rd_hit_d, best_valid_q, best_valid_d;
  logic [WORD_WIDTH-1:0] best_id_q, best_id_d, best_qv_q, best_qv_d;
  logic sc_found_q, sc_found_d;
  logic [WORD_WIDTH-1:0] sc_hops_q, sc_hops_d, sc_qv_q, sc_qv_d, sc_id_q, sc_id_d;

  logic [WORD_WIDTH-1:0] tbl_id_q     [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0] tbl_energy_q [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0] tbl_hops_q   [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0] tbl_qv_q     [MAX_NEIGHBORS];
  logic          tbl_we;
  logic [AW-1:0] tbl_widx;

  logic [WORD_WIDTH-1:0] cur_id, cur_energy, cur_hops, cur_qv;
  logic empty, last, id_match, better;
  logic nxt_found;
  logic [WORD_WIDTH-1:0] nxt_hops, nxt_qv, nxt_id;

  assign cur_id     = tbl_id_q[idx_q];
  assign cur_energy = tbl_energy_q[idx_q];
  assign cur_hops   = tbl_hops_q[idx_q];
  assign cur_qv     = tbl_qv_q[idx_q];
  assign empty      = (count_q == '0);
  assign last       = (({1'b0, idx_q} + CW'(1)) == count_q);
  assign id_match   = (cur_id == op_id_q);

  // Candidate must be strictly closer to the CH; rank by fewest hops, then highest Q.
  assign better    = (cur_hops < my_hops_q) &&
                     (!sc_found_q || (cur_hops < sc_hops_q) ||
                      ((cur_hops == sc_hops_q) && (cur_qv > sc_qv_q)));
  assign nxt_found = sc_found_q | better;
  assign nxt_hops  = better ? cur_hops : sc_hops_q;
  assign nxt_qv    = better ? cur_qv   : sc_qv_q;
  assign nxt_id    = better ? cur_id   : sc_id_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    match_idx_d   = match_idx_q;
    match_found_d = match_found_q;
    drop_d        = drop_q;
    op_id_d       = op_id_q;
    op_energy_d   = op_energy_q;
    op_hops_d     = op_hops_q;
    op_qv_d       = op_qv_q;
    my_hops_d     = my_hops_q;
    m_src_d       = m_src_q;
    m_hops_d      = m_hops_q;
    m_qv_d        = m_qv_q;
    m_energy_d    = m_energy_q;
    rd_hit_d      = rd_hit_q;
    best_id_d     = best_id_q;
    best_qv_d     = best_qv_q;
    best_valid_d  = best_valid_q;
    sc_found_d    = sc_found_q;
    sc_hops_d     = sc_hops_q;
    sc_qv_d       = sc_qv_q;
    sc_id_d       = sc_id_q;
    tbl_we        = 1'b0;
    tbl_widx      = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        drop_d = 1'b0;
        if (clr) begin
          count_d = '0;
        end else if (wr_req) begin
          op_id_d       = nodeID;
          op_energy_d   = nodeEnergy;
          op_hops_d     = nodeHops;
          op_qv_d       = nodeQValue;
          match_found_d = 1'b0;
          match_idx_d   = '0;
          state_d       = S_WSEARCH;
        end else if (rd_req) begin
          op_id_d = rd_id;
          state_d = S_RSEARCH;
        end else if (scan_req) begin
          my_hops_d  = myHops;
          sc_found_d = 1'b0;
          sc_hops_d  = '0;
          sc_qv_d    = '0;
          sc_id_d    = '0;
          state_d    = S_SCAN;
        end
      end
      S_WSEARCH: begin
        if (!empty && id_match) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
          state_d       = S_WRITE;
        end else if (empty || last) begin
          state_d = S_WRITE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_WRITE: begin
        if (match_found_q) begin
          tbl_we   = 1'b1;
          tbl_widx = match_idx_q;
        end else if (count_q != C_FULL) begin
          tbl_we   = 1'b1;
          tbl_widx = count_q[AW-1:0];
          count_d  = count_q + CW'(1);
        end else begin
          drop_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_RSEARCH: begin
        if (!empty && id_match) begin
          m_src_d    = cur_id;
          m_hops_d   = cur_hops;
          m_qv_d     = cur_qv;
          m_energy_d = cur_energy;
          rd_hit_d   = 1'b1;
          state_d    = S_DONE;
        end else if (empty || last) begin
          m_src_d    = '0;
          m_hops_d   = '0;
          m_qv_d     = '0;
          m_energy_d = '0;
          rd_hit_d   = 1'b0;
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_SCAN: begin
        if (empty) begin
          best_valid_d = 1'b0;
          best_id_d    = '0;
          best_qv_d    = '0;
          state_d      = S_DONE;
        end else begin
          sc_found_d = nxt_found;
          sc_hops_d  = nxt_hops;
          sc_qv_d    = nxt_qv;
          sc_id_d    = nxt_id;
          if (last) begin
            best_valid_d = nxt_found;
            best_id_d    = nxt_found ? nxt_id : '0;
            best_qv_d    = nxt_found ? nxt_qv : '0;
            state_d      = S_DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      match_idx_q   <= '0;
      match_found_q <= 1'b0;
      drop_q        <= 1'b0;
      op_id_q       <= '0;
      op_energy_q   <= '0;
      op_hops_q     <= '0;
      op_qv_q       <= '0;
      my_hops_q     <= '0;
      m_src_q       <= '0;
      m_hops_q      <= '0;
      m_qv_q        <= '0;
      m_energy_q    <= '0;
      rd_hit_q      <= 1'b0;
      best_id_q     <= '0;
      best_qv_q     <= '0;
      best_valid_q  <= 1'b0;
      sc_found_q    <= 1'b0;
      sc_hops_q     <= '0;
      sc_qv_q       <= '0;
      sc_id_q       <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      match_idx_q   <= match_idx_d;
      match_found_q <= match_found_d;
      drop_q        <= drop_d;
      op_id_q       <= op_id_d;
      op_energy_q   <= op_energy_d;
      op_hops_q     <= op_hops_d;
      op_qv_q       <= op_qv_d;
      my_hops_q     <= my_hops_d;
      m_src_q       <= m_src_d;
      m_hops_q      <= m_hops_d;
      m_qv_q        <= m_qv_d;
      m_energy_q    <= m_energy_d;
      rd_hit_q      <= rd_hit_d;
      best_id_q     <= best_id_d;
      best_qv_q     <= best_qv_d;
      best_valid_q  <= best_valid_d;
      sc_found_q    <= sc_found_d;
      sc_hops_q     <= sc_hops_d;
      sc_qv_q       <= sc_qv_d;
      sc_id_q       <= sc_id_d;
    end
  end

  // Table storage is not reset: entries beyond count_q are never looked at.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_id_q[tbl_widx]     <= op_id_q;
      tbl_energy_q[tbl_widx] <= op_energy_q;
      tbl_hops_q[tbl_widx]   <= op_hops_q;
      tbl_qv_q[tbl_widx]     <= op_qv_q;
    end
  end

  assign mSourceID     = m_src_q;
  assign mHopsFromCH   = m_hops_q;
  assign mQValue       = m_qv_q;
  assign mEnergyLeft   = m_energy_q;
  assign rd_hit        = rd_hit_q;
  assign bestID        = best_id_q;
  assign bestQValue    = best_qv_q;
  assign best_valid    = best_valid_q;
  assign neighborCount = WORD_WIDTH'(count_q);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign wr_drop       = (state_q == S_DONE) && drop_q;

endmodule

`default_nettype wire

// File: tb/tb_neighbor_table.sv
// ============================================================================
// tb_neighbor_table : directed + randomized checks against a queue-based table model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neighbor_table;

  localparam int N = 16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_req = 1'b0, rd_req = 1'b0, scan_req = 1'b0, clr = 1'b0;
  logic [W-1:0] nodeID = '0, nodeEnergy = '0, nodeHops = '0, nodeQValue = '0;
  logic [W-1:0] rd_id = '0, myHops = '0;
  logic [W-1:0] mSourceID, mHopsFromCH, mQValue, mEnergyLeft;
  logic [W-1:0] bestID, bestQValue, neighborCount;
  logic         rd_hit, best_valid, busy, done, wr_drop;

  neighbor_table #(.MAX_NEIGHBORS(N), .WORD_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .nodeID(nodeID), .nodeEnergy(nodeEnergy), .nodeHops(nodeHops), .nodeQValue(nodeQValue),
    .rd_req(rd_req), .rd_id(rd_id),
    .scan_req(scan_req), .myHops(myHops), .clr(clr),
    .mSourceID(mSourceID), .mHopsFromCH(mHopsFromCH), .mQValue(mQValue), .mEnergyLeft(mEnergyLeft), .rd_hit(rd_hit),
    .bestID(bestID), .bestQValue(bestQValue), .best_valid(best_valid),
    .neighborCount(neighborCount), .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] id, en, hp, qv;
  } ent_t;

  ent_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic last_hit = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mfind(input logic [W-1:0] id);
    foreach (tbl[i]) if (tbl[i].id == id) return i;
    return -1;
  endfunction

  // Waits for the single done pulse, then confirms it lasted exactly one cycle.
  task automatic wait_done(input string tag, output logic drop);
    bit seen = 0;
    drop = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1;
        drop = wr_drop;
        break;
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    tick();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 0);
    chk({tag, "_idle_after"}, {31'd0, busy}, 0);
  endtask

  task automatic do_write(input logic [W-1:0] id, en, hp, qv);
    logic drop, exp_drop;
    int   k;
    ent_t e;
    e.id = id; e.en = en; e.hp = hp; e.qv = qv;
    k = mfind(id);
    exp_drop = 1'b0;
    if (k >= 0) tbl[k] = e;
    else if (tbl.size() < N) tbl.push_back(e);
    else exp_drop = 1'b1;
    wr_req = 1'b1; nodeID = id; nodeEnergy = en; nodeHops = hp; nodeQValue = qv;
    tick();
    wr_req = 1'b0;
    nodeID = W'($urandom); nodeEnergy = W'($urandom); nodeHops = W'($urandom); nodeQValue = W'($urandom);
    wait_done("write", drop);
    chk("wr_drop", {31'd0, drop}, {31'd0, exp_drop});
    chk("count_after_write", {16'd0, neighborCount}, tbl.size());
  endtask

  task automatic do_read(input logic [W-1:0] id);
    logic drop;
    int   k = mfind(id);
    rd_req = 1'b1; rd_id = id;
    tick();
    rd_req = 1'b0; rd_id = W'($urandom);
    wait_done("read", drop);
    last_hit = (k >= 0);
    chk("rd_hit", {31'd0, rd_hit}, (k >= 0) ? 1 : 0);
    chk("mSourceID",   {16'd0, mSourceID},   (k >= 0) ? {16'd0, tbl[k].id} : 0);
    chk("mHopsFromCH", {16'd0, mHopsFromCH}, (k >= 0) ? {16'd0, tbl[k].hp} : 0);
    chk("mQValue",     {16'd0, mQValue},     (k >= 0) ? {16'd0, tbl[k].qv} : 0);
    chk("mEnergyLeft", {16'd0, mEnergyLeft}, (k >= 0) ? {16'd0, tbl[k].en} : 0);
  endtask

  task automatic do_scan(input logic [W-1:0] mh);
    logic drop;
    int   b = -1;
    // Reference: among entries closer than mh, fewest hops wins, then largest Q, then earliest slot.
    foreach (tbl[i]) begin
      if (tbl[i].hp < mh) begin
        if (b < 0) b = i;
        else if (tbl[i].hp < tbl[b].hp) b = i;
        else if (tbl[i].hp == tbl[b].hp && tbl[i].qv > tbl[b].qv) b = i;
      end
    end
    scan_req = 1'b1; myHops = mh;
    tick();
    scan_req = 1'b0; myHops = W'($urandom);
    wait_done("scan", drop);
    chk("best_valid", {31'd0, best_valid}, (b >= 0) ? 1 : 0);
    chk("bestID",     {16'd0, bestID},     (b >= 0) ? {16'd0, tbl[b].id} : 0);
    chk("bestQValue", {16'd0, bestQValue}, (b >= 0) ? {16'd0, tbl[b].qv} : 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tbl.delete();
    chk("clr_count", {16'd0, neighborCount}, 0);
    chk("clr_no_done", {31'd0, done}, 0);
    chk("clr_not_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    int ndone;
    // Reset state
    repeat (3) tick();
    chk("rst_count", {16'd0, neighborCount}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_hit", {31'd0, rd_hit}, 0);
    chk("rst_best_valid", {31'd0, best_valid}, 0);
    chk("rst_mQValue", {16'd0, mQValue}, 0);
    chk("rst_bestID", {16'd0, bestID}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Empty table: immediate miss and no candidate
    do_read(16'd5);
    do_scan(16'd10);

    // Basic writes, overwrite, lookup and scan
    do_write(16'd5, 16'd100, 16'd2, 16'd10);
    do_write(16'd9, 16'd200, 16'd1, 16'd20);
    do_write(16'd3, 16'd300, 16'd1, 16'd30);
    chk("count_three", {16'd0, neighborCount}, 3);
    do_write(16'd9, 16'd250, 16'd1, 16'd40);
    do_read(16'd9);
    chk("rewrite_q", {16'd0, mQValue}, 40);
    do_read(16'd77);
    do_scan(16'd2);
    chk("scan2_id", {16'd0, bestID}, 9);
    do_scan(16'd1);
    chk("scan1_none", {31'd0, best_valid}, 0);
    do_scan(16'd0);

    // Simultaneous write+read, then read while busy: only the write runs
    wr_req = 1'b1; rd_req = 1'b1;
    nodeID = 16'd50; nodeEnergy = 16'd7; nodeHops = 16'd4; nodeQValue = 16'd8; rd_id = 16'd50;
    tbl.push_back('{id: 16'd50, en: 16'd7, hp: 16'd4, qv: 16'd8});
    tick();
    wr_req = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("single_done", ndone, 1);
    chk("rd_ignored", {31'd0, rd_hit}, {31'd0, last_hit});
    chk("count_after_dual", {16'd0, neighborCount}, tbl.size());
    do_clr();

    // Fill to capacity, then a new ID is dropped
    for (int i = 0; i < N; i++) do_write(W'(100 + i), W'($urandom), W'($urandom_range(0, 5)), W'($urandom_range(0, 15)));
    do_write(16'd99, 16'd1, 16'd1, 16'd1);
    chk("full_count", {16'd0, neighborCount}, N);
    do_read(16'd99);
    do_read(16'd115);
    do_write(16'd115, 16'd9, 16'd0, 16'd3);
    do_scan(16'd3);

    // Randomized mix against the model
    do_clr();
    for (int it = 0; it < 120; it++) begin
      int op = $urandom_range(0, 9);
      if (op <= 3) do_write(W'($urandom_range(0, 23)), W'($urandom), W'($urandom_range(0, 5)), W'($urandom_range(0, 7)));
      else if (op <= 5) do_read(W'($urandom_range(0, 25)));
      else if (op <= 8) do_scan(W'($urandom_range(0, 6)));
      else if ($urandom_range(0, 3) == 0) do_clr();
    end

    // Reset in the middle of a 16-entry scan
    do_clr();
    for (int i = 0; i < N; i++) do_write(W'(200 + i), W'($urandom), W'($urandom_range(0, 3)), W'($urandom_range(1, 15)));
    do_scan(16'd7);
    do_read(16'd205);
    scan_req = 1'b1; myHops = 16'd7;
    tick();
    scan_req = 1'b0;
    repeat (3) tick();
    chk("mid_scan_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_count", {16'd0, neighborCount}, 0);
    chk("arst_best_valid", {31'd0, best_valid}, 0);
    chk("arst_bestID", {16'd0, bestID}, 0);
    chk("arst_rd_hit", {31'd0, rd_hit}, 0);
    chk("arst_mQValue", {16'd0, mQValue}, 0);
    tbl.delete();
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    do_read(16'd205);
    do_write(16'd1, 16'd2, 16'd3, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neighbor_table.md
NEIGHBOR_TABLE -- requirements
Module: neighbor_table

Interface
REQ-001 SHALL have parameter MAX_NEIGHBORS, default 16, meaning entry capacity (power of 2, 2..64).
REQ-002 SHALL have parameter WORD_WIDTH, default 16, meaning width of every stored field.
REQ-003 SHALL have ports: clk in 1 (single clock, rising edge); rst in 1 (reset, asynchronous, active-high).
REQ-004 SHALL have ports: wr_req in 1 (write request pulse); nodeID, nodeEnergy, nodeHops, nodeQValue in WORD_WIDTH each (entry to write).
REQ-005 SHALL have ports: rd_req in 1 (lookup pulse); rd_id in WORD_WIDTH (ID to look up).
REQ-006 SHALL have ports: scan_req in 1 (best-hop scan pulse); myHops in WORD_WIDTH (own hopsFromCH); clr in 1 (synchronous table clear).
REQ-007 SHALL have ports: mSourceID, mHopsFromCH, mQValue, mEnergyLeft out WORD_WIDTH each (lookup result); rd_hit out 1.
REQ-008 SHALL have ports: bestID, bestQValue out WORD_WIDTH; best_valid out 1.
REQ-009 SHALL have ports: neighborCount out WORD_WIDTH; busy out 1; done out 1 (one-cycle completion pulse); wr_drop out 1 (one-cycle pulse, table full).

Function
REQ-010 SHALL store up to MAX_NEIGHBORS entries {ID, energy, hops, Q} in registers, occupying indices 0..neighborCount-1 contiguously.
REQ-011 SHALL implement FSM states IDLE, WSEARCH, WRITE, RSEARCH, SCAN, DONE.
REQ-012 SHALL, in IDLE, accept one request per cycle with priority clr > wr_req > rd_req > scan_req; lower-priority requests in the same cycle are discarded.
REQ-013 SHALL hold busy=1 in every state except IDLE; requests arriving while busy=1 are ignored.
REQ-014 SHALL latch request operands (node fields, rd_id, myHops) on acceptance; later input changes have no effect.
REQ-015 SHALL examine one entry per cycle in WSEARCH/RSEARCH/SCAN, index 0 upward, stopping at neighborCount-1 or at first ID match (search states only).
REQ-016 SHALL, on write with ID match at index i, overwrite energy/hops/Q at i in WRITE; count unchanged.
REQ-017 SHALL, on write with no match and neighborCount<MAX_NEIGHBORS, append at index neighborCount and increment neighborCount in WRITE.
REQ-018 SHALL, on write with no match and table full, leave table unchanged and pulse wr_drop together with done.
REQ-019 SHALL, on read match, load m* outputs from the entry and set rd_hit=1; on miss, set m* to 0 and rd_hit=0; outputs hold until next read.
REQ-020 SHALL, in SCAN, consider only entries with hops < myHops; select minimum hops, then maximum Q (unsigned), ties to lower index.
REQ-021 SHALL, after SCAN, set bestID/bestQValue/best_valid=1 for the selected entry, or best_valid=0 and bestID/bestQValue=0 when none qualifies; outputs hold until next scan.
REQ-022 SHALL treat neighborCount=0 as immediate miss/no-candidate: one search/scan cycle, then DONE.
REQ-023 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; request-to-done latency = entries examined + 2 cycles (write adds 1 for WRITE).
REQ-024 SHALL, on clr accepted in IDLE, set neighborCount=0 next cycle without a done pulse; stored data need not be cleared.
REQ-025 SHALL compare all fields as unsigned WORD_WIDTH values; myHops=0 yields no candidate.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, neighborCount=0, busy=0, done=0, wr_drop=0, rd_hit=0, best_valid=0, all m*/best* outputs=0, asynchronously.
REQ-027 SHALL abort any in-progress operation on rst assertion with no done pulse; table contents after reset are invalid.

Verification
REQ-028 Write IDs 5,9,3 (hops 2,1,1; Q 10,20,30) -> neighborCount=3, three done pulses, wr_drop never set.
REQ-029 Rewrite ID 9 with Q=40, then rd_id=9 -> neighborCount stays 3, rd_hit=1, mQValue=40, mHopsFromCH=1.
REQ-030 Above table, scan myHops=2 -> bestID=9, bestQValue=40, best_valid=1; scan myHops=1 -> best_valid=0.
REQ-031 Fill 16 entries, write new ID 99 -> wr_drop and done same cycle, neighborCount=16; rd_id=99 -> rd_hit=0.
REQ-032 wr_req and rd_req same cycle, then rd_req while busy -> only write executes, single done; clr -> neighborCount=0.
REQ-033 Assert rst during SCAN of 16 entries -> busy=0, outputs 0, no done pulse, neighborCount=0.
